// File: rtl/gray_rx_checker.sv
// Gray-stream receiver: decodes each strobed Gray word to binary two clocks later and
// checks that consecutive decoded values move by +1, -1 or 0, counting illegal jumps.
module gray_rx_checker #(
    parameter int N          = 4,
    parameter int CNT_W      = 8,
    parameter bit ALLOW_DOWN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N:1]       gray_in,
    input  logic             gray_valid,
    input  logic             clear_err,
    output logic [N:1]       bin_out,
    output logic             bin_valid,
    output logic [1:0]       dir,
    output logic             step_err,
    output logic             sticky_err,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;
    localparam logic [1:0] DIR_BAD  = 2'b11;

    logic [N:1]       g1_q, g1_d;
    logic             v1_q, v1_d;
    logic [N:1]       prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic [N:1]       bin_q, bin_d;
    logic             bin_valid_q, bin_valid_d;
    logic [1:0]       dir_q, dir_d;
    logic             step_err_q, step_err_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [N:1]       b;
    logic [N:1]       diff;

    always_comb begin
        g1_d = gray_valid ? gray_in : g1_q;
        v1_d = gray_valid;

        // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
        b    = '0;
        b[N] = g1_q[N];
        for (int i = N - 1; i >= 1; i--) begin
            b[i] = b[i+1] ^ g1_q[i];
        end
        diff = b - prev_q;

        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        bin_d       = bin_q;
        dir_d       = dir_q;
        bin_valid_d = 1'b0;
        step_err_d  = 1'b0;

        if (v1_q) begin
            bin_d       = b;
            bin_valid_d = 1'b1;
            prev_d      = b;
            have_prev_d = 1'b1;
            if (!have_prev_q) begin
                dir_d = DIR_HOLD;
            end else if (diff == '0) begin
                dir_d = DIR_HOLD;
            end else if (diff == N'(1)) begin
                dir_d = DIR_UP;
            end else if (diff == '1) begin
                dir_d      = DIR_DOWN;
                step_err_d = !ALLOW_DOWN;
            end else begin
                dir_d      = DIR_BAD;
                step_err_d = 1'b1;
            end
        end

        // A clear in the same cycle as an error wins; the step_err pulse is unaffected.
        sticky_d  = sticky_q;
        err_cnt_d = err_cnt_q;
        if (clear_err) begin
            sticky_d  = 1'b0;
            err_cnt_d = '0;
        end else if (step_err_d) begin
            sticky_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g1_q        <= '0;
            v1_q        <= 1'b0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            bin_q       <= '0;
            bin_valid_q <= 1'b0;
            dir_q       <= DIR_HOLD;
            step_err_q  <= 1'b0;
            sticky_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            g1_q        <= g1_d;
            v1_q        <= v1_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            bin_q       <= bin_d;
            bin_valid_q <= bin_valid_d;
            dir_q       <= dir_d;
            step_err_q  <= step_err_d;
            sticky_q    <= sticky_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bin_out    = bin_q;
    assign bin_valid  = bin_valid_q;
    assign dir        = dir_q;
    assign step_err   = step_err_q;
    assign sticky_err = sticky_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_gray_rx_checker.sv
// Bench for gray_rx_checker: two instances share one input stream, one permissive
// (down steps legal, 8-bit count) and one strict (down steps illegal, 2-bit count).
module tb_gray_rx_checker;

    logic       clk;
    logic       rst;
    logic [4:1] gray_in;
    logic       gray_valid;
    logic       clear_err;

    logic [4:1] bin_out_a, bin_out_b;
    logic       bin_valid_a, bin_valid_b;
    logic [1:0] dir_a, dir_b;
    logic       step_err_a, step_err_b;
    logic       sticky_a, sticky_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    gray_rx_checker #(.N(4), .CNT_W(8), .ALLOW_DOWN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
        .clear_err(clear_err), .bin_out(bin_out_a), .bin_valid(bin_valid_a),
        .dir(dir_a), .step_err(step_err_a), .sticky_err(sticky_a), .err_count(cnt_a)
    );

    gray_rx_checker #(.N(4), .CNT_W(2), .ALLOW_DOWN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
        .clear_err(clear_err), .bin_out(bin_out_b), .bin_valid(bin_valid_b),
        .dir(dir_b), .step_err(step_err_b), .sticky_err(sticky_b), .err_count(cnt_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic clr_s = 1'b0;

    // scoreboard: {bin[3:0], dir[1:0]} with the cycle it must appear on
    logic [5:0] exp_q[$];
    int         cyc_q[$];

    logic [4:1] m_prev = '0;
    bit         m_have = 1'b0;
    int         exp_cnt_a = 0;
    int         exp_cnt_b = 0;
    logic       exp_stk_a = 1'b0;
    logic       exp_stk_b = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        clr_s = clear_err;
    end

    // monitor
    logic [5:0] e;
    logic       exp_v;
    logic       st_a, st_b;
    always @(negedge clk) begin
        if (!rst) begin
            exp_cnt_a = 0;
            exp_cnt_b = 0;
            exp_stk_a = 1'b0;
            exp_stk_b = 1'b0;
        end else begin
            st_a  = 1'b0;
            st_b  = 1'b0;
            exp_v = (exp_q.size() > 0) && (cyc_q[0] == cyc);
            chk("bin_valid_a", 32'(bin_valid_a), 32'(exp_v));
            chk("bin_valid_b", 32'(bin_valid_b), 32'(exp_v));
            if (exp_v) begin
                e = exp_q.pop_front();
                void'(cyc_q.pop_front());
                st_a = (e[1:0] == 2'b11);
                st_b = e[1];
                chk("bin_out_a", 32'(bin_out_a), 32'(e[5:2]));
                chk("bin_out_b", 32'(bin_out_b), 32'(e[5:2]));
                chk("dir_a", 32'(dir_a), 32'(e[1:0]));
                chk("dir_b", 32'(dir_b), 32'(e[1:0]));
            end
            chk("step_err_a", 32'(step_err_a), 32'(st_a));
            chk("step_err_b", 32'(step_err_b), 32'(st_b));
            if (clr_s) begin
                exp_cnt_a = 0; exp_cnt_b = 0; exp_stk_a = 1'b0; exp_stk_b = 1'b0;
            end else begin
                if (st_a) begin
                    exp_stk_a = 1'b1;
                    if (exp_cnt_a < 255) exp_cnt_a++;
                end
                if (st_b) begin
                    exp_stk_b = 1'b1;
                    if (exp_cnt_b < 3) exp_cnt_b++;
                end
            end
            chk("err_count_a", 32'(cnt_a), 32'(exp_cnt_a));
            chk("err_count_b", 32'(cnt_b), 32'(exp_cnt_b));
            chk("sticky_a", 32'(sticky_a), 32'(exp_stk_a));
            chk("sticky_b", 32'(sticky_b), 32'(exp_stk_b));
        end
    end

    // driver tasks
    task automatic send(input logic [4:1] g, input logic [4:1] ebin, input logic [1:0] edir,
                        input logic clr);
        @(posedge clk); #1;
        gray_valid = 1'b1;
        gray_in    = g;
        clear_err  = clr;
        exp_q.push_back({ebin, edir});
        cyc_q.push_back(cyc + 2);
        m_prev = ebin;
        m_have = 1'b1;
    endtask

    task automatic idle(input logic clr);
        @(posedge clk); #1;
        gray_valid = 1'b0;
        gray_in    = 4'($urandom_range(0, 15));
        clear_err  = clr;
    endtask

    task automatic send_model(input logic [4:1] nxt, input logic clr);
        logic [4:1] d;
        logic [1:0] ed;
        d = nxt - m_prev;
        if (!m_have || d == 4'd0) ed = 2'b00;
        else if (d == 4'd1)       ed = 2'b01;
        else if (d == 4'd15)      ed = 2'b10;
        else                      ed = 2'b11;
        send(nxt ^ (nxt >> 1), nxt, ed, clr);
    endtask

    task automatic check_reset_outputs();
        chk("rst_bin_valid", 32'({bin_valid_a, bin_valid_b}), 32'(0));
        chk("rst_bin_out", 32'({bin_out_a, bin_out_b}), 32'(0));
        chk("rst_dir", 32'({dir_a, dir_b}), 32'(0));
        chk("rst_errs", 32'({step_err_a, step_err_b, sticky_a, sticky_b}), 32'(0));
        chk("rst_count", 32'({cnt_a, cnt_b}), 32'(0));
    endtask

    task automatic apply_reset();
        @(posedge clk); #3;
        rst        = 1'b0;
        gray_valid = 1'b0;
        clear_err  = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        m_have = 1'b0;
        m_prev = '0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        logic [4:1] gray;
        logic [4:1] bin;
        logic [1:0] dir;
        int         gap;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{4'b0000, 4'd0,  2'b00, 0};  // first sample
        tbl[1]  = '{4'b0001, 4'd1,  2'b01, 0};
        tbl[2]  = '{4'b0011, 4'd2,  2'b01, 0};
        tbl[3]  = '{4'b0010, 4'd3,  2'b01, 0};
        tbl[4]  = '{4'b0110, 4'd4,  2'b01, 0};
        tbl[5]  = '{4'b1001, 4'd14, 2'b11, 2};  // jump 4 -> 14
        tbl[6]  = '{4'b1000, 4'd15, 2'b01, 0};
        tbl[7]  = '{4'b0000, 4'd0,  2'b01, 1};  // wrap up 15 -> 0
        tbl[8]  = '{4'b0001, 4'd1,  2'b01, 0};
        tbl[9]  = '{4'b0010, 4'd3,  2'b11, 0};  // jump 1 -> 3
        tbl[10] = '{4'b0011, 4'd2,  2'b10, 3};  // down
        tbl[11] = '{4'b0001, 4'd1,  2'b10, 0};
        tbl[12] = '{4'b0000, 4'd0,  2'b10, 0};
        tbl[13] = '{4'b1000, 4'd15, 2'b10, 0};  // wrap down 0 -> 15
        tbl[14] = '{4'b1000, 4'd15, 2'b00, 1};  // hold
        tbl[15] = '{4'b1100, 4'd8,  2'b11, 0};  // jump 15 -> 8

        gray_in    = '0;
        gray_valid = 1'b0;
        clear_err  = 1'b0;
        rst        = 1'b1;
        #2;
        rst = 1'b0;
        #5;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < tbl[i].gap; k++) idle(1'b0);
            send(tbl[i].gray, tbl[i].bin, tbl[i].dir, 1'b0);
        end

        // jump whose error lands on the same edge as a clear: clear wins
        send(4'b0111, 4'd5, 2'b11, 1'b0);
        idle(1'b1);
        idle(1'b0);
        send(4'b0101, 4'd6, 2'b01, 1'b0);
        idle(1'b0);

        // reset while a sample sits in stage 1: it must never emerge
        send(4'b0100, 4'd7, 2'b01, 1'b0);
        apply_reset();
        send(4'b0011, 4'd2, 2'b00, 1'b0);
        send(4'b0010, 4'd3, 2'b01, 1'b0);
        send(4'b1010, 4'd12, 2'b11, 1'b0);

        // random stream of mostly legal steps with gaps, jumps and clears
        for (int n = 0; n < 200; n++) begin
            int r;
            logic [4:1] nxt;
            for (int k = $urandom_range(0, 3) - 2; k > 0; k--) idle($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 9);
            if (r <= 3)      nxt = m_prev + 4'd1;
            else if (r <= 5) nxt = m_prev - 4'd1;
            else if (r == 6) nxt = m_prev;
            else             nxt = 4'($urandom_range(0, 15));
            send_model(nxt, $urandom_range(0, 19) == 0);
        end

        repeat (5) idle(1'b0);
        chk("drain", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
